// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and status/display outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  logic        key_ss;
  logic        key_lc;
  logic        tick_ms;
  logic [1:0]  state;
  logic        overflow;
  logic [29:0] timeOut;

  modport master (output key_ss, key_lc, input tick_ms, state, overflow, timeOut);
  modport slave  (input key_ss, key_lc, output tick_ms, state, overflow, timeOut);
endinterface

// File: rtl/stopwatch_ctrl.sv
// Millisecond stopwatch controller: key debounce, IDLE/RUN/LAP/PAUSE control,
// 1 ms prescaler, 4-digit BCD count and registered six-digit display code.
module stopwatch_ctrl #(
  parameter int CLK_DIV  = 50000,
  parameter int DEBOUNCE = 250000,
  parameter int WRAP     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, LAP = 2'b10, PAUSE = 2'b11} state_t;

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int PS_W = $clog2(CLK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
  localparam logic [29:0]     DISP_RESET = {5'd20, 5'd20, 5'd10, 15'd0};

  // index 0 = start/stop key, index 1 = lap/clear key
  logic [1:0]      key_raw, key_meta, key_sync, key_lvl, key_press;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state_q, state_d;
  logic [PS_W-1:0] presc_q;
  logic [3:0][3:0] cnt_q, cnt_d, lap_q, disp_src;
  logic            ovf_q;
  logic [29:0]     disp_q;

  logic ss_p, lc_p, running, tick, at_max, clear, snap, carry;

  assign key_raw = {bus.key_lc, bus.key_ss};
  assign ss_p    = key_press[0];
  assign lc_p    = key_press[1];

  // A level is accepted only after DEBOUNCE consecutive samples disagree with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta  <= '1;
      key_sync  <= '1;
      key_lvl   <= '1;
      key_press <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
      for (int i = 0; i < 2; i++) begin
        key_press[i] <= 1'b0;
        if (key_sync[i] != key_lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            key_lvl[i]   <= key_sync[i];
            key_press[i] <= ~key_sync[i];
            db_cnt[i]    <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign running = (state_q == RUN) || (state_q == LAP);
  assign tick    = running && (presc_q == PS_LAST);
  assign at_max  = (cnt_q == 16'h9999);

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    snap    = 1'b0;
    unique case (state_q)
      IDLE:  if (ss_p) state_d = RUN;
      RUN:   if (ss_p) state_d = PAUSE;
             else if (lc_p) begin
               state_d = LAP;
               snap    = 1'b1;
             end
      LAP:   if (ss_p) state_d = PAUSE;
             else if (lc_p) state_d = RUN;
      PAUSE: if (ss_p) state_d = RUN;
             else if (lc_p) begin
               state_d = IDLE;
               clear   = 1'b1;
             end
      default: state_d = IDLE;
    endcase
    // Saturating variant stops the watch at 9.999 regardless of key activity
    if (tick && at_max && WRAP == 0) state_d = PAUSE;
  end

  always_comb begin
    cnt_d = cnt_q;
    carry = tick && !at_max;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    if (tick && at_max && WRAP != 0) cnt_d = '0;
  end

  assign disp_src = (state_q == LAP) ? lap_q : cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= DISP_RESET;
    end else begin
      state_q <= state_d;
      // PAUSE keeps the sub-millisecond residue
      if (clear || state_q == IDLE) presc_q <= '0;
      else if (running)             presc_q <= tick ? '0 : presc_q + 1'b1;
      if (clear) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (tick && at_max) ovf_q <= 1'b1;
      end
      if (snap) lap_q <= cnt_q;
      disp_q <= {5'd20, 5'd20, 5'd10 + {1'b0, disp_src[3]}, {1'b0, disp_src[2]},
                 {1'b0, disp_src[1]}, {1'b0, disp_src[0]}};
    end
  end

  assign bus.state    = state_q;
  assign bus.tick_ms  = tick;
  assign bus.overflow = ovf_q;
  assign bus.timeOut  = disp_q;

endmodule
